ldm_stm_sequencer: RTL and testbench

- Initiator-side sequencer for multi-register memory transfers: STM, LDM, PUSH and POP.
- Walks an 8+1-bit register list and issues one word access per cycle to data memory, driving its write enable, opcode, address and write data.
- Captures read data one cycle after each read address, writes loaded values to the register file, then reports the final base/SP value for writeback.
- Sits between the execute stage and data memory; the pipeline stalls while `busy` is high.

---
 rtl/ldm_stm_sequencer.sv | 161 ++++++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ldm_stm_sequencer.sv
// Multi-register transfer sequencer (STM/LDM/PUSH/POP): one word access per cycle, loads retired a cycle later.
// Optional: define LSU_ALIGN_CHECK_EN to fault on a misaligned base instead of ignoring base_addr[1:0].
module ldm_stm_sequencer #(
  parameter int ADDR_W    = 32,
  parameter int MEM_IDX_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [8:0]           reg_list,
  input  logic [2:0]           base_reg,
  input  logic [ADDR_W-1:0]    base_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_write_en,
  output logic [6:0]           mem_opcode,
  output logic [MEM_IDX_W-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  output logic [3:0]           rf_rd_addr,
  input  logic [31:0]          rf_rd_data,
  output logic                 rf_wr_en,
  output logic [3:0]           rf_wr_addr,
  output logic [31:0]          rf_wr_data,
  output logic                 pc_written,
  output logic                 wb_en,
  output logic [ADDR_W-1:0]    wb_value,
  output logic                 fault
);
  typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;
  localparam logic [1:0] M_STM = 2'b00, M_LDM = 2'b01, M_PUSH = 2'b10;

  state_t               state, state_nx;
  logic [1:0]           mode_q;
  logic [8:0]           list_q;
  logic [ADDR_W-1:0]    addr_q, wb_q;
  logic                 wb_ok_q, fault_q, pend_vld;
  logic [3:0]           pend_idx;

  logic [8:0]           eff_list;
  logic [3:0]           n, cur_idx;
  logic [ADDR_W-1:0]    four_n, addr_shr;
  logic [MEM_IDX_W-1:0] word_idx;
  logic                 is_load, last, misalign;
  logic [6:0]           op_code;

`ifdef LSU_ALIGN_CHECK_EN
  assign misalign = |base_addr[1:0];
`else
  assign misalign = 1'b0;
`endif

  // bit8 (R14/R15) only participates for PUSH/POP
  assign eff_list = reg_list & {mode[1], 8'hFF};
  assign four_n   = ADDR_W'({n, 2'b00});
  assign is_load  = mode_q[0];
  assign last     = (list_q & (list_q - 9'd1)) == 9'd0;
  assign addr_shr = addr_q >> 2;

  if (MEM_IDX_W > ADDR_W) begin : g_zext
    assign word_idx = {{(MEM_IDX_W-ADDR_W){1'b0}}, addr_shr};
  end else begin : g_trunc
    assign word_idx = addr_shr[MEM_IDX_W-1:0];
  end

  always_comb begin
    n = '0;
    for (int i = 0; i < 9; i++) n = n + {3'b0, eff_list[i]};
  end

  // lowest set bit wins; bit8 maps to R14 for PUSH, R15 for POP
  always_comb begin
    cur_idx = 4'd0;
    for (int i = 8; i >= 0; i--)
      if (list_q[i]) cur_idx = 4'(i);
    if (cur_idx == 4'd8) cur_idx = is_load ? 4'd15 : 4'd14;
  end

  always_comb begin
    case (mode_q)
      2'b00:   op_code = 7'b1100000;
      2'b01:   op_code = 7'b1100100;
      2'b10:   op_code = 7'b1011010;
      default: op_code = 7'b1011110;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    busy         = (state != IDLE);
    done         = (state == DONE);
    mem_write_en = 1'b0;
    mem_opcode   = 7'd0;
    mem_addr     = '0;
    mem_wdata    = 32'd0;
    rf_rd_addr   = 4'd0;
    case (state)
      IDLE:  if (start) state_nx = (n == 4'd0 || misalign) ? DONE : XFER;
      XFER: begin
        mem_opcode = op_code;
        mem_addr   = word_idx;
        if (!is_load) begin
          rf_rd_addr   = cur_idx;
          mem_wdata    = rf_rd_data;
          mem_write_en = 1'b1;
        end
        if (last) state_nx = is_load ? DRAIN : DONE;
      end
      DRAIN: begin
        mem_opcode = op_code;
        state_nx   = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign wb_en      = done & wb_ok_q;
  assign wb_value   = done ? wb_q : '0;
  assign fault      = done & fault_q;
  assign rf_wr_en   = pend_vld;
  assign rf_wr_addr = pend_vld ? pend_idx : 4'd0;
  assign rf_wr_data = pend_vld ? mem_rdata : 32'd0;
  assign pc_written = pend_vld && (pend_idx == 4'd15);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= 2'b00;
      list_q   <= 9'd0;
      addr_q   <= '0;
      wb_q     <= '0;
      wb_ok_q  <= 1'b0;
      fault_q  <= 1'b0;
      pend_vld <= 1'b0;
      pend_idx <= 4'd0;
    end else begin
      pend_vld <= (state == XFER) && is_load;
      pend_idx <= cur_idx;
      case (state)
        IDLE: if (start) begin
          mode_q  <= mode;
          list_q  <= eff_list;
          addr_q  <= (mode == M_PUSH) ? base_addr - four_n : base_addr;
          wb_q    <= (mode == M_PUSH) ? base_addr - four_n : base_addr + four_n;
          wb_ok_q <= (n != 4'd0) && !misalign && !(mode == M_LDM && reg_list[base_reg]);
          fault_q <= (n != 4'd0) && misalign;
        end
        XFER: begin
          list_q <= list_q & (list_q - 9'd1);
          addr_q <= addr_q + ADDR_W'(4);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench: directed transfers push expected stores, rf writes and completions; a negedge monitor pops and compares.
module tb_ldm_stm_sequencer;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [8:0]  reg_list = 9'd0;
  logic [2:0]  base_reg = 3'd0;
  logic [31:0] base_addr = 32'd0;
  logic        busy, done, mem_write_en, rf_wr_en, pc_written, wb_en, fault;
  logic [6:0]  mem_opcode;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, rf_rd_data, rf_wr_data, wb_value;
  logic [3:0]  rf_rd_addr, rf_wr_addr;

  localparam logic [6:0] OP_STM = 7'b1100000, OP_LDM = 7'b1100100, OP_PUSH = 7'b1011010, OP_POP = 7'b1011110;

  ldm_stm_sequencer #(.ADDR_W(32), .MEM_IDX_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .reg_list(reg_list), .base_reg(base_reg),
    .base_addr(base_addr), .busy(busy), .done(done), .mem_write_en(mem_write_en),
    .mem_opcode(mem_opcode), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
    .rf_wr_data(rf_wr_data), .pc_written(pc_written), .wb_en(wb_en), .wb_value(wb_value), .fault(fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] rf_mem [16];
  always_comb rf_rd_data = rf_mem[rf_rd_addr];

  function automatic logic [31:0] memf(input logic [31:0] idx);
    case (idx)
      32'h80:  return 32'h11;
      32'h81:  return 32'h22;
      32'h3FE: return 32'h77;
      32'h3FF: return 32'h88;
      default: return 32'hBAD0_0000 | {16'd0, idx[15:0]};
    endcase
  endfunction
  always @(posedge clk) mem_rdata <= memf(mem_addr);

  typedef struct { int cyc; logic [31:0] a; logic [31:0] d; logic [6:0] op; logic pc; } ev_t;
  typedef struct { int cyc; logic wb; logic [31:0] v; logic f; } dn_t;
  ev_t q_st[$], q_rf[$];
  dn_t q_dn[$];

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  ev_t es, er;
  dn_t ed;
  always @(negedge clk) if (!rst) begin
    if (mem_write_en) begin
      if (q_st.size() == 0) chk("unexpected_store", mem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        es = q_st.pop_front();
        chk("st_cycle", 64'(cyc), 64'(es.cyc));
        chk("st_addr", mem_addr, es.a);
        chk("st_wdata", mem_wdata, es.d);
        chk("st_opcode", mem_opcode, es.op);
      end
    end
    if (rf_wr_en) begin
      if (q_rf.size() == 0) chk("unexpected_rf_write", rf_wr_addr, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        er = q_rf.pop_front();
        chk("rf_cycle", 64'(cyc), 64'(er.cyc));
        chk("rf_addr", rf_wr_addr, er.a);
        chk("rf_data", rf_wr_data, er.d);
        chk("rf_pc_written", pc_written, er.pc);
        chk("rf_opcode", mem_opcode, er.op);
      end
    end else if (pc_written) chk("pc_written_alone", pc_written, 0);
    if (done) begin
      if (q_dn.size() == 0) chk("unexpected_done", done, 0);
      else begin
        ed = q_dn.pop_front();
        chk("done_cycle", 64'(cyc), 64'(ed.cyc));
        chk("wb_en", wb_en, ed.wb);
        if (ed.wb) chk("wb_value", wb_value, ed.v);
        chk("fault", fault, ed.f);
        chk("busy_in_done", busy, 1);
      end
    end else begin
      if (wb_en) chk("wb_en_without_done", wb_en, 0);
      if (fault) chk("fault_without_done", fault, 0);
    end
  end

  task automatic issue(input logic [1:0] m, input logic [8:0] l, input logic [2:0] br,
                       input logic [31:0] b, output int t);
    @(posedge clk); #1;
    t = cyc; start = 1'b1; mode = m; reg_list = l; base_reg = br; base_addr = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic settle(input string nm);
    repeat (10) @(posedge clk);
    #1;
    chk({nm, "_store_q_empty"}, q_st.size(), 0);
    chk({nm, "_rf_q_empty"}, q_rf.size(), 0);
    chk({nm, "_done_q_empty"}, q_dn.size(), 0);
    chk({nm, "_idle"}, busy, 0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_ctrl"}, {busy, done, mem_write_en, rf_wr_en, pc_written, wb_en, fault,
                        mem_opcode, rf_rd_addr, rf_wr_addr}, 0);
    chk({nm, "_mem"}, {mem_addr, mem_wdata}, 0);
    chk({nm, "_rf_wb"}, {rf_wr_data, wb_value}, 0);
  endtask

  initial begin
    int t;
    for (int i = 0; i < 16; i++) rf_mem[i] = 32'hF000_0000 | i;
    rf_mem[0] = 32'hA; rf_mem[1] = 32'hC; rf_mem[2] = 32'hB; rf_mem[14] = 32'hE0E;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // STM R0,R2 from 0x100
    issue(2'b00, 9'h005, 3'd0, 32'h100, t);
    q_st.push_back('{t+1, 32'h40, 32'hA, OP_STM, 1'b0});
    q_st.push_back('{t+2, 32'h41, 32'hB, OP_STM, 1'b0});
    q_dn.push_back('{t+3, 1'b1, 32'h108, 1'b0});
    settle("stm");

    // LDM R1,R3 from 0x200 with base R1 in list; a start during busy must be ignored
    issue(2'b01, 9'h00A, 3'd1, 32'h200, t);
    q_rf.push_back('{t+2, 32'd1, 32'h11, OP_LDM, 1'b0});
    q_rf.push_back('{t+3, 32'd3, 32'h22, OP_LDM, 1'b0});
    q_dn.push_back('{t+4, 1'b0, 32'h0, 1'b0});
    chk("ldm_busy", busy, 1);
    start = 1'b1; mode = 2'b00; reg_list = 9'h1FF; base_addr = 32'h0;
    @(posedge clk); #1;
    start = 1'b0;
    settle("ldm");

    // LDM with base not in list -> writeback enabled
    issue(2'b01, 9'h001, 3'd5, 32'h200, t);
    q_rf.push_back('{t+2, 32'd0, 32'h11, OP_LDM, 1'b0});
    q_dn.push_back('{t+3, 1'b1, 32'h204, 1'b0});
    settle("ldm_wb");

    // PUSH R0,R1,R14 with SP=0x1000
    issue(2'b10, 9'h103, 3'd0, 32'h1000, t);
    q_st.push_back('{t+1, 32'h3FD, 32'hA, OP_PUSH, 1'b0});
    q_st.push_back('{t+2, 32'h3FE, 32'hC, OP_PUSH, 1'b0});
    q_st.push_back('{t+3, 32'h3FF, 32'hE0E, OP_PUSH, 1'b0});
    q_dn.push_back('{t+4, 1'b1, 32'hFF4, 1'b0});
    settle("push");

    // POP R7,R15 with SP=0xFF8
    issue(2'b11, 9'h180, 3'd0, 32'hFF8, t);
    q_rf.push_back('{t+2, 32'd7, 32'h77, OP_POP, 1'b0});
    q_rf.push_back('{t+3, 32'd15, 32'h88, OP_POP, 1'b1});
    q_dn.push_back('{t+4, 1'b1, 32'h1000, 1'b0});
    settle("pop");

    // PUSH wrapping below address zero
    issue(2'b10, 9'h003, 3'd0, 32'h4, t);
    q_st.push_back('{t+1, 32'h3FFF_FFFF, 32'hA, OP_PUSH, 1'b0});
    q_st.push_back('{t+2, 32'h0, 32'hC, OP_PUSH, 1'b0});
    q_dn.push_back('{t+3, 1'b1, 32'hFFFF_FFFC, 1'b0});
    settle("push_wrap");

    // empty lists: STM with 0, LDM with only bit8 (masked)
    issue(2'b00, 9'h000, 3'd0, 32'h100, t);
    q_dn.push_back('{t+1, 1'b0, 32'h0, 1'b0});
    settle("empty_stm");
    issue(2'b01, 9'h100, 3'd0, 32'h100, t);
    q_dn.push_back('{t+1, 1'b0, 32'h0, 1'b0});
    settle("empty_ldm");

    // misaligned base
    issue(2'b00, 9'h001, 3'd0, 32'h102, t);
`ifdef LSU_ALIGN_CHECK_EN
    q_dn.push_back('{t+1, 1'b0, 32'h0, 1'b1});
`else
    q_st.push_back('{t+1, 32'h40, 32'hA, OP_STM, 1'b0});
    q_dn.push_back('{t+2, 1'b1, 32'h106, 1'b0});
`endif
    settle("misalign");

    // reset at T+2 of a 4-register STM: only the T+1 store is seen
    issue(2'b00, 9'h00F, 3'd0, 32'h40, t);
    q_st.push_back('{t+1, 32'h10, 32'hA, OP_STM, 1'b0});
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midop_reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    settle("midop");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
